// File: rtl/des_pkg.sv
// Shared definitions for the DES block-mode front end: sequencer states, block width,
// core direction flags and the FIPS reference vectors.
package des_pkg;

  localparam int DES_BLK_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_RUN,
    ST_SETTLE,
    ST_OUT,
    ST_ERR
  } state_t;

  localparam logic FLAG_ENC = 1'b0;
  localparam logic FLAG_DEC = 1'b1;

  localparam logic [DES_BLK_W-1:0] FIPS_KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [DES_BLK_W-1:0] FIPS_PT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [DES_BLK_W-1:0] FIPS_CT  = 64'h85E8_1354_0F0A_B405;

endpackage

// File: rtl/des_cbc_sequencer.sv
// ECB/CBC block sequencer in front of the iterative DES core: one block in flight,
// valid/ready on both sides, sticky error when the core fails to finish in time.
module des_cbc_sequencer
  import des_pkg::*;
#(
  parameter int CORE_TIMEOUT = 64,
  parameter int DOUT_SKEW    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cbc_en,
  input  logic                 decrypt,
  input  logic [DES_BLK_W-1:0] key,
  input  logic [DES_BLK_W-1:0] iv,
  input  logic                 iv_load,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DES_BLK_W-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DES_BLK_W-1:0] m_data,
  output logic                 m_last,
  output logic                 core_rst_n,
  output logic [DES_BLK_W-1:0] core_key,
  output logic [DES_BLK_W-1:0] core_din,
  output logic                 core_flag,
  input  logic [DES_BLK_W-1:0] core_dout,
  input  logic                 core_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int TW       = $clog2(CORE_TIMEOUT + 1);
  localparam int SKEW_CYC = (DOUT_SKEW < 1) ? 1 : DOUT_SKEW;
  localparam int SW       = $clog2(SKEW_CYC + 1);

  state_t               state, state_nx;
  logic [TW-1:0]        tmo_cnt;
  logic [SW-1:0]        settle_cnt;
  logic [DES_BLK_W-1:0] chain_q, iv_q, blk_q, chain_src;
  logic                 last_q, cbc_q, dec_q;
  logic                 accept, timeout_hit, settle_done;

  assign accept      = s_valid && s_ready;
  assign timeout_hit = (tmo_cnt >= TW'(CORE_TIMEOUT - 1));
  assign settle_done = (settle_cnt == SW'(SKEW_CYC - 1));
  // An iv_load arriving with the first block must chain against the new IV.
  assign chain_src   = iv_load ? iv : chain_q;

  assign busy = (state != ST_IDLE);
  assign err  = (state == ST_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_KICK;
      ST_KICK:   state_nx = ST_RUN;
      ST_RUN:    if (core_ready) state_nx = ST_SETTLE;
                 else if (timeout_hit) state_nx = ST_ERR;
      ST_SETTLE: if (settle_done) state_nx = ST_OUT;
      ST_OUT:    if (m_ready) state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_ERR;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready    <= 1'b0;
      core_rst_n <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      core_din   <= '0;
      core_key   <= '0;
      core_flag  <= FLAG_ENC;
      chain_q    <= '0;
      iv_q       <= '0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      cbc_q      <= 1'b0;
      dec_q      <= 1'b0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      // Registered from next state so both read as reset values right after reset release.
      s_ready    <= (state_nx == ST_IDLE);
      core_rst_n <= (state_nx inside {ST_RUN, ST_SETTLE, ST_OUT});

      if (state == ST_IDLE && iv_load) begin
        chain_q <= iv;
        iv_q    <= iv;
      end

      if (state == ST_IDLE && accept) begin
        blk_q     <= s_data;
        last_q    <= s_last;
        cbc_q     <= cbc_en;
        dec_q     <= decrypt;
        core_key  <= key;
        core_flag <= decrypt ? FLAG_DEC : FLAG_ENC;
        core_din  <= (cbc_en && !decrypt) ? (s_data ^ chain_src) : s_data;
      end

      if (state == ST_KICK) tmo_cnt <= '0;
      else if (state == ST_RUN && tmo_cnt != TW'(CORE_TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                    settle_cnt <= '0;

      if (state == ST_SETTLE && settle_done) begin
        m_valid <= 1'b1;
        m_last  <= last_q;
        if (!dec_q) begin
          m_data <= core_dout;
          if (cbc_q) chain_q <= core_dout;
        end else begin
          m_data <= core_dout ^ (cbc_q ? chain_q : '0);
          if (cbc_q) chain_q <= blk_q;
        end
      end

      if (state == ST_OUT && m_ready) begin
        m_valid <= 1'b0;
        if (last_q && cbc_q) chain_q <= iv_q;
      end
    end
  end

endmodule

// File: tb/tb_des_cbc_sequencer.sv
// Bench for des_cbc_sequencer: a behavioural DES core with random latency, a message-level
// ECB/CBC reference model and directed plus randomized scenarios.
module tb_des_cbc_sequencer;
  import des_pkg::*;

  localparam int TMO  = 64;
  localparam int SKEW = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cbc_en, decrypt, iv_load, s_valid, s_last, m_ready;
  logic [63:0] key, iv, s_data;
  logic        s_ready, m_valid, m_last, core_rst_n, core_flag, core_ready, busy, err;
  logic [63:0] m_data, core_key, core_din, core_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  des_cbc_sequencer #(.CORE_TIMEOUT(TMO), .DOUT_SKEW(SKEW)) dut (
    .clk(clk), .reset(reset), .cbc_en(cbc_en), .decrypt(decrypt), .key(key), .iv(iv),
    .iv_load(iv_load), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_rst_n(core_rst_n), .core_key(core_key), .core_din(core_din), .core_flag(core_flag),
    .core_dout(core_dout), .core_ready(core_ready), .busy(busy), .err(err)
  );

  // ---------------- DES reference (FIPS 46-3 tables) ----------------
  byte unsigned ip_t [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  byte unsigned fp_t [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  byte unsigned e_t [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                             16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  byte unsigned p_t [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  byte unsigned pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                               60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                               61,53,45,37,29,21,13,5,28,20,12,4};
  byte unsigned pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  byte unsigned sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  byte unsigned sbox_t [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] d, input logic dec);
    logic [55:0] cd;
    logic [27:0] c, dd;
    logic [47:0] sk [16];
    logic [47:0] ex, x;
    logic [63:0] t, pre, o;
    logic [31:0] l, r, fs, f, nr;
    logic [5:0]  six;
    int          row, col, v;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    c  = cd[55:28];
    dd = cd[27:0];
    for (int rr = 0; rr < 16; rr++) begin
      for (int s = 0; s < sh_t[rr]; s++) begin
        c  = {c[26:0], c[27]};
        dd = {dd[26:0], dd[27]};
      end
      cd = {c, dd};
      for (int i = 0; i < 48; i++) sk[rr][47-i] = cd[56-pc2_t[i]];
    end
    for (int i = 0; i < 64; i++) t[63-i] = d[64-ip_t[i]];
    l = t[63:32];
    r = t[31:0];
    for (int rr = 0; rr < 16; rr++) begin
      for (int i = 0; i < 48; i++) ex[47-i] = r[32-e_t[i]];
      x = ex ^ sk[dec ? 15 - rr : rr];
      for (int s = 0; s < 8; s++) begin
        six = x[47-6*s -: 6];
        row = {six[5], six[0]};
        col = six[4:1];
        v   = sbox_t[s*64 + row*16 + col];
        fs[31-4*s -: 4] = v[3:0];
      end
      for (int i = 0; i < 32; i++) f[31-i] = fs[32-p_t[i]];
      nr = l ^ f;
      l  = r;
      r  = nr;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) o[63-i] = pre[64-fp_t[i]];
    return o;
  endfunction

  // ---------------- behavioural DES core ----------------
  int          core_lat   = 4;
  bit          core_stuck = 1'b0;
  int          ccnt       = 0;
  logic [63:0] c_din, c_key, c_res;
  logic        c_flag;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      ccnt = 0;
      core_ready <= 1'b0;
      core_dout  <= {$urandom, $urandom};
    end else begin
      ccnt++;
      if (ccnt == 1) begin
        c_din = core_din;
        c_key = core_key;
      end else begin
        if (ccnt == 2) begin
          c_flag = core_flag;
          c_res  = des_ref(c_key, c_din, c_flag);
        end
        total++;
        if (core_din !== c_din || core_key !== c_key || core_flag !== c_flag) begin
          bad++;
          $display("FAIL core_inputs_stable: din=%h key=%h flag=%b want din=%h key=%h flag=%b",
                   core_din, core_key, core_flag, c_din, c_key, c_flag);
        end
      end
      if (!core_stuck && ccnt == core_lat) core_ready <= 1'b1;
      if (ccnt < core_lat + SKEW)       core_dout <= {$urandom, $urandom};
      else if (ccnt == core_lat + SKEW) core_dout <= c_res;
    end
  end

  // core_flag watcher for the decrypt scenario
  bit flag_watch = 1'b0;
  int flag_bad   = 0;
  always @(negedge clk) if (flag_watch && busy && core_flag !== FLAG_DEC) flag_bad++;

  // ---------------- message-level reference model ----------------
  logic [63:0] mdl_chain = '0, mdl_iv = '0;

  task automatic model_iv(input logic [63:0] v);
    mdl_chain = v;
    mdl_iv    = v;
  endtask

  task automatic model_block(input logic [63:0] d, input logic lst, output logic [63:0] exp);
    if (!cbc_en) exp = des_ref(key, d, decrypt);
    else if (!decrypt) begin
      exp = des_ref(key, d ^ mdl_chain, 1'b0);
      mdl_chain = exp;
    end else begin
      exp = des_ref(key, d, 1'b1) ^ mdl_chain;
      mdl_chain = d;
    end
    if (lst && cbc_en) mdl_chain = mdl_iv;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_iv(input logic [63:0] v);
    @(negedge clk);
    iv = v;
    iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    model_iv(v);
  endtask

  task automatic run_block(input logic [63:0] d, input logic lst, input int stall, input logic with_iv,
                           output logic [63:0] got, output logic got_last, output bit ok);
    int n;
    ok = 1'b1;
    got = '0;
    got_last = 1'b0;
    m_ready = (stall == 0);
    @(negedge clk);
    s_data = d; s_last = lst; s_valid = 1'b1; iv_load = with_iv;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    if (!s_ready) ok = 1'b0;
    @(negedge clk);
    s_valid = 1'b0; iv_load = 1'b0; s_data = {$urandom, $urandom}; s_last = 1'($urandom);
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    if (!m_valid) begin
      ok = 1'b0;
      m_ready = 1'b0;
      return;
    end
    got = m_data;
    got_last = m_last;
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        if (!m_valid || m_data !== got) ok = 1'b0;
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
    if (m_valid) ok = 1'b0;
    m_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, m_valid, m_last, core_rst_n, core_flag, busy, err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=0000000",
               {s_ready, m_valid, m_last, core_rst_n, core_flag, busy, err});
    end
    total++;
    if ({m_data, core_din, core_key} !== 192'b0) begin
      bad++;
      $display("FAIL reset_data: m_data=%h core_din=%h core_key=%h want all 0", m_data, core_din, core_key);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || core_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: s_ready=%b busy=%b core_rst_n=%b want 1 0 0", s_ready, busy, core_rst_n);
    end
  endtask

  task automatic test_ecb_enc();
    logic [63:0] got; logic gl; bit ok;
    cbc_en = 1'b0; decrypt = 1'b0; key = FIPS_KEY; core_lat = 5;
    run_block(FIPS_PT, 1'b1, 2, 1'b0, got, gl, ok);
    total++;
    if (!ok || got !== FIPS_CT || gl !== 1'b1) begin
      bad++;
      $display("FAIL ecb_enc_fips: got=%h last=%b ok=%b want=%h last=1", got, gl, ok, FIPS_CT);
    end
  endtask

  task automatic test_ecb_dec();
    logic [63:0] got; logic gl; bit ok;
    cbc_en = 1'b0; decrypt = 1'b1; key = FIPS_KEY; core_lat = 7;
    flag_bad = 0; flag_watch = 1'b1;
    run_block(FIPS_CT, 1'b0, 0, 1'b0, got, gl, ok);
    flag_watch = 1'b0;
    total++;
    if (!ok || got !== FIPS_PT || gl !== 1'b0) begin
      bad++;
      $display("FAIL ecb_dec_fips: got=%h last=%b ok=%b want=%h last=0", got, gl, ok, FIPS_PT);
    end
    total++;
    if (flag_bad !== 0) begin
      bad++;
      $display("FAIL ecb_dec_flag: cycles with core_flag!=1 got=%0d want=0", flag_bad);
    end
  endtask

  task automatic test_cbc();
    logic [63:0] pt [3];
    logic [63:0] ct [3];
    logic [63:0] got, exp; logic gl; bit ok;
    cbc_en = 1'b1; decrypt = 1'b0; key = {$urandom, $urandom};
    load_iv('0);
    for (int i = 0; i < 3; i++) pt[i] = {$urandom, $urandom};
    for (int msg = 0; msg < 2; msg++) begin
      for (int i = 0; i < 3; i++) begin
        core_lat = 2 + int'($urandom_range(0, 10));
        model_block(pt[i], i == 2, exp);
        if (msg == 0) ct[i] = exp;
        run_block(pt[i], i == 2, int'($urandom_range(0, 3)), 1'b0, got, gl, ok);
        total++;
        if (!ok || got !== ct[i] || gl !== (i == 2)) begin
          bad++;
          $display("FAIL cbc_enc msg%0d blk%0d: got=%h last=%b ok=%b want=%h", msg, i, got, gl, ok, ct[i]);
        end
      end
    end
    decrypt = 1'b1;
    load_iv('0);
    for (int i = 0; i < 3; i++) begin
      core_lat = 2 + int'($urandom_range(0, 10));
      model_block(ct[i], i == 2, exp);
      run_block(ct[i], i == 2, int'($urandom_range(0, 3)), 1'b0, got, gl, ok);
      total++;
      if (!ok || got !== pt[i]) begin
        bad++;
        $display("FAIL cbc_dec blk%0d: got=%h ok=%b want=%h", i, got, ok, pt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, exp_a, exp_b, held;
    int n;
    cbc_en = 1'b0; decrypt = 1'b0; key = {$urandom, $urandom}; core_lat = 3;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    model_block(a, 1'b0, exp_a);
    model_block(b, 1'b1, exp_b);
    m_ready = 1'b0;
    @(negedge clk);
    s_data = a; s_last = 1'b0; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    s_data = b; s_last = 1'b1;
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    held = m_data;
    total++;
    if (!m_valid || held !== exp_a) begin
      bad++;
      $display("FAIL bp_first: got=%h valid=%b want=%h", held, m_valid, exp_a);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc%0d: m_valid=%b m_data=%h s_ready=%b want 1 %h 0", i, m_valid, m_data, s_ready, held);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    total++;
    if (!m_valid || m_data !== exp_b || m_last !== 1'b1) begin
      bad++;
      $display("FAIL bp_second: got=%h valid=%b last=%b want=%h last=1", m_data, m_valid, m_last, exp_b);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] d, exp, got; logic gl, lst, wiv; bit ok;
    int len;
    for (int m = 0; m < 12; m++) begin
      cbc_en  = 1'($urandom);
      decrypt = 1'($urandom);
      key     = {$urandom, $urandom};
      len     = 1 + int'($urandom_range(0, 2));
      wiv     = 1'($urandom);
      if (wiv) iv = {$urandom, $urandom};
      for (int b = 0; b < len; b++) begin
        core_lat = 2 + int'($urandom_range(0, 12));
        d   = {$urandom, $urandom};
        lst = (b == len - 1);
        if (wiv && b == 0) model_iv(iv);
        model_block(d, lst, exp);
        run_block(d, lst, int'($urandom_range(0, 3)), wiv && b == 0, got, gl, ok);
        total++;
        if (!ok || got !== exp || gl !== lst) begin
          bad++;
          $display("FAIL random m%0d b%0d cbc=%b dec=%b: got=%h last=%b ok=%b want=%h last=%b",
                   m, b, cbc_en, decrypt, got, gl, ok, exp, lst);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit hold_ok;
    core_stuck = 1'b1;
    cbc_en = 1'b0; decrypt = 1'b0;
    @(negedge clk);
    s_data = {$urandom, $urandom}; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!err && n < 200);
    total++;
    if (n !== TMO + 1 || err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_cycle: err after %0d cycles (err=%b) want %0d", n, err, TMO + 1);
    end
    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || err !== 1'b1 || busy !== 1'b1 || core_rst_n !== 1'b0)
        hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) begin
      bad++;
      $display("FAIL err_sticky: s_ready=%b m_valid=%b err=%b busy=%b want 0 0 1 1", s_ready, m_valid, err, busy);
    end
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared: err=%b busy=%b want 0 0", err, busy);
    end
    reset = 1'b0;
    core_stuck = 1'b0;
    model_iv('0);
  endtask

  task automatic test_async_reset();
    logic [63:0] d, exp, got; logic gl; bit ok;
    int n;
    cbc_en = 1'b1; decrypt = 1'b0; key = {$urandom, $urandom}; core_lat = 30;
    load_iv({$urandom, $urandom});
    @(negedge clk);
    s_data = {$urandom, $urandom}; s_last = 1'b0; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (!core_rst_n && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({s_ready, m_valid, m_last, core_rst_n, core_flag, busy, err} !== 7'b0 ||
        {m_data, core_din, core_key} !== 192'b0) begin
      bad++;
      $display("FAIL async_reset: flags=%b m_data=%h core_din=%h core_key=%h want all 0",
               {s_ready, m_valid, m_last, core_rst_n, core_flag, busy, err}, m_data, core_din, core_key);
    end
    @(negedge clk);
    reset = 1'b0;
    model_iv('0);
    core_lat = 6;
    d = {$urandom, $urandom};
    model_block(d, 1'b1, exp);
    run_block(d, 1'b1, 1, 1'b0, got, gl, ok);
    total++;
    if (!ok || got !== exp || gl !== 1'b1) begin
      bad++;
      $display("FAIL after_async_reset: got=%h last=%b ok=%b want=%h", got, gl, ok, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cbc_en = 1'b0; decrypt = 1'b0; key = '0; iv = '0; iv_load = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    test_ecb_enc();
    test_ecb_dec();
    test_cbc();
    test_backpressure();
    test_random();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
